store_trace_fifo: RTL
=====================

Name: store_trace_fifo

Overview:
- Passive tap on the CPU data-memory write port (memwrite / aluresult / writedata), in parallel with dmem.
- Captures every committed store as an {address, data} record in a FIFO and drains records over a valid/ready interface to the result dumper / trace checker.
- Detects the halt store to HALT_ADDR and freezes cycle and store counters, replacing ad-hoc finish detection in benches.

Parameters:
- DATA_W, 32, width of address, data and counters.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- HALT_ADDR, 32'h00007fff, store address that signals program end.
- FILT_LO, 32'h00000400, lower bound (inclusive) of recorded address window; used only with STORE_TRACE_FILTER_EN.
- FILT_HI, 32'h00000fff, upper bound (inclusive) of recorded address window; used only with STORE_TRACE_FILTER_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  CPU memwrite.
- daddr  in  DATA_W  CPU aluresult (store address).
- wdata  in  DATA_W  CPU writedata.
- tr_valid  out  1  head record available (equals !empty).
- tr_ready  in  1  consumer accepts head record.
- tr_addr  out  DATA_W  head record address.
- tr_data  out  DATA_W  head record data.
- full  out  1  FIFO holds DEPTH records.
- empty  out  1  FIFO holds 0 records.
- overflow  out  1  sticky: a store was dropped.
- halt  out  1  sticky: halt store seen.
- cycle_count  out  DATA_W  cycles since reset release, frozen at halt.
- store_count  out  DATA_W  stores recorded, excluding the halt store and dropped stores.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, overflow=0, halt=0, cycle_count=0, store_count=0. Outputs are then tr_valid=0, empty=1, full=0; tr_addr/tr_data=0.
- Clock cycle: a posedge with rst_n high.
- cycle_count: +1 every cycle while halt=0, including the cycle that sets halt. Holds afterwards. Wraps modulo 2^DATA_W.
- Store event: we=1 at a posedge while halt=0.
- Halt store (daddr == HALT_ADDR): sets halt on that edge. The store is not pushed and store_count is unchanged.
- After halt=1, all further we pulses are ignored. Draining continues normally.
- Push: any non-halt store event. Record {daddr, wdata} is written at the tail; store_count +1.
- Pop: tr_valid && tr_ready at a posedge; the head advances.
- Head record is visible combinationally from storage, so a push is seen on tr_* the cycle after it is written. Push-to-visible latency is 1 cycle.
- Full with pop and push on the same edge: both happen, the record is accepted, and the count stays DEPTH.
- Full without pop: the record is dropped, overflow set (sticky until reset), store_count unchanged.
- Empty with push and pop on the same edge: no pop occurs because tr_valid=0; the push takes effect.
- Pointers carry an extra wrap bit. full and empty are decoded from pointer equality, so no separate counter is kept.
- tr_addr/tr_data must stay stable while tr_valid=1 and tr_ready=0.
- Reset mid-operation: all contents discarded immediately, in-flight records lost, no X on outputs.

Optional Feature:
- Macro STORE_TRACE_FILTER_EN.
- Defined: a non-halt store is pushed only if FILT_LO <= daddr <= FILT_HI (unsigned). Out-of-window stores are not pushed, not counted, and do not set overflow. Halt detection is unaffected.
- Undefined: every non-halt store is pushed. FILT_LO/FILT_HI are unused.

Test Plan:
- Reset, then 5 stores {0x400+4i, 0xA0+i} with tr_ready=0 -> store_count=5, tr_valid=1, head tr_addr=0x400, tr_data=0xA0, records unchanged while stalled.
- 18 stores with tr_ready=0, DEPTH=16 -> full=1 after 16th, overflow=1 after 17th, store_count=16; drain yields exactly the first 16 records in order, then empty=1.
- Fill to 16, then tr_ready=1 and a store 0xDEAD at 0x800 on the same edge -> full stays 1, overflow=0, 0xDEAD emerges last.
- Reset, 3 stores, then store to 0x7fff at cycle 20 -> halt=1, cycle_count freezes at 20, store_count=3; later we pulses ignored; 3 records still drain.
- Assert rst_n=0 mid-drain with 7 records queued -> empty=1, tr_valid=0, all counters and flags 0 immediately, before the next clock edge.
- STORE_TRACE_FILTER_EN defined: stores to 0x100, 0x400, 0xfff, 0x1000 -> only 0x400 and 0xfff recorded, store_count=2, overflow=0.

Source files
------------

// File: rtl/store_trace_fifo.sv
// store_trace_fifo: passive store tap that queues {addr,data} records, detects the halt store and freezes counters; optional macro STORE_TRACE_FILTER_EN limits recording to [FILT_LO,FILT_HI]
module store_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 16,
    parameter logic [DATA_W-1:0] HALT_ADDR = 32'h00007fff,
    parameter logic [DATA_W-1:0] FILT_LO = 32'h00000400,
    parameter logic [DATA_W-1:0] FILT_HI = 32'h00000fff
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [DATA_W-1:0] tr_addr,
    output logic [DATA_W-1:0] tr_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              halt,
    output logic [DATA_W-1:0] cycle_count,
    output logic [DATA_W-1:0] store_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [AW:0] wp, rp;
    logic store, is_halt, in_win, want, pop, push, drop;

    assign store = we && !halt;
    assign is_halt = daddr == HALT_ADDR;
`ifdef STORE_TRACE_FILTER_EN
    assign in_win = daddr >= FILT_LO && daddr <= FILT_HI;
`else
    assign in_win = 1'b1;
`endif
    assign want = store && !is_halt && in_win;
    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign tr_valid = !empty;
    assign pop = tr_valid && tr_ready;
    assign push = want && (!full || pop);
    assign drop = want && full && !pop;
    assign tr_addr = empty ? '0 : mem_addr[rp[AW-1:0]];
    assign tr_data = empty ? '0 : mem_data[rp[AW-1:0]];

    // record storage; contents are masked by empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wp[AW-1:0]] <= daddr;
            mem_data[wp[AW-1:0]] <= wdata;
        end
    end

    // pointers, sticky flags and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            overflow <= 1'b0;
            halt <= 1'b0;
            cycle_count <= '0;
            store_count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push) store_count <= store_count + 1'b1;
            if (drop) overflow <= 1'b1;
            if (store && is_halt) halt <= 1'b1;
            if (!halt) cycle_count <= cycle_count + 1'b1;
        end
    end
endmodule
